arrow_key_decoder: RTL and testbench
====================================

# arrow_key_decoder

Turns the raw PS/2 byte stream into clean per-player arrow events for the two rhythm-game processors. It parses make, break and E0-extended sequences and suppresses typematic auto-repeat, so a held key yields exactly one event. Each player's events are buffered in a small FIFO drained by that player's processor. It sits between the PS/2 interface (scan bytes) and the processors' key-pressed / arrow-input ports, and also raises the game-reset request for the 'R' key.

## Interface
- FIFO_DEPTH, 4: entries per player FIFO; power of two, ≥2.

- clock  in  1  system clock (10 MHz PLL output)
- resetn  in  1  asynchronous, active-low reset
- scan_code  in  8  byte from PS/2 interface
- scan_valid  in  1  one-cycle strobe, scan_code valid
- p1_arrow  out  3  head of player-1 FIFO: 001 up, 010 left, 011 down, 100 right; 000 when empty
- p1_valid  out  1  player-1 FIFO non-empty
- p1_ready  in  1  pop player-1 head when p1_valid
- p2_arrow, p2_valid, p2_ready: same as player 1, for player 2
- game_reset_req  out  1  one-cycle pulse on make of 'R' (0x2D)
- overflow  out  2  sticky drop flags; bit0 player 1, bit1 player 2

## Operation
- Key map, player 1: 0x1D up, 0x1C left, 0x1B down, 0x23 right. Player 2: 0x75 up, 0x6B left, 0x72 down, 0x74 right, accepted with or without the E0 prefix. 0x2D is reset. All other codes are ignored.
- Parser FSM advances only on scan_valid.
  - States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0).
  - E0: IDLE→EXT; any other state stays put.
  - F0: IDLE→BRK, EXT→EXT_BRK; BRK and EXT_BRK stay put.
  - Any other byte in IDLE/EXT is a make; in BRK/EXT_BRK it is a break. The FSM then returns to IDLE.
- Held bitmap: 8 bits, one per mapped arrow key.
  - Make with held bit clear: set the bit and push the arrow code.
  - Make with held bit set: ignored (typematic suppression).
  - Break: clear the bit; nothing is pushed.
- Reset key: a make of 0x2D pulses game_reset_req. On the same edge the block flushes both FIFOs, clears the held bitmap, clears overflow, and forces the FSM to IDLE. A break of 0x2D does nothing.
- FIFO rules:
  - A pop occurs when valid && ready.
  - Push to a full FIFO with a simultaneous pop: both happen and the FIFO stays full.
  - Push to a full FIFO without a pop: the event is dropped and that player's overflow bit is set; the held bit is still set.
  - Pop while empty: ignored.
- Pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (resetn low, asynchronous): FSM IDLE, bitmap 0, FIFOs empty, p*_valid 0, p*_arrow 000, game_reset_req 0, overflow 00.
- The final byte of a sequence, strobed on edge N, is visible at edge N+1: p*_valid high and p*_arrow equal to the code. Latency is one cycle.
- game_reset_req is high for exactly the cycle after edge N.
- p*_arrow is a combinational read of the head entry; p*_valid is registered. Head data is stable while valid && !ready.
- A pop at edge M exposes the next entry, or valid 0, after edge M.
- Back-to-back scan_valid on consecutive cycles is fully supported.
- resetn asserted mid-sequence (e.g. after E0 F0) discards the partial sequence.

## Structure
- Package arrow_pkg holds:
  - arrow codes ARROW_NONE/UP/LEFT/DOWN/RIGHT (3-bit);
  - scan-code constants: the eight arrow keys, KEY_RESET 0x2D, PFX_EXT 0xE0, PFX_BRK 0xF0;
  - parser state encoding.
- One sub-module, arrow_event_fifo (3-bit wide, FIFO_DEPTH deep, push/pop/full/empty/flush), instantiated twice.
- Parser FSM, bitmap and key map live in the top module.

## Test plan
- Bytes 1D, then F0 1D → p1_valid at N+1 with p1_arrow 001; no second push; held bit cleared after the break.
- Typematic: 74 ×5 with no break → exactly one p2 entry, 100. Then F0 74, 74 → a second entry, 100.
- Extended: E0 6B → p2 entry 010. E0 F0 6B → no push, and the 0x6B held bit clears.
- Overflow, FIFO_DEPTH=4 with p1_ready=0: six distinct makes with breaks between → 4 entries and overflow[0]=1. Then assert p1_ready → entries drain in push order; overflow stays 1.
- Full-FIFO push with simultaneous pop → entry count stays 4, overflow stays 0, and the new arrow lands at the tail.
- Make 2D with both FIFOs non-empty → game_reset_req pulses one cycle, both valids drop next cycle, overflow clears. A resetn pulse after a lone E0 → the following 75 is parsed as a fresh make.

Source files
------------

// File: rtl/arrow_pkg.sv
// -----------------------------------------------------------------------------
// arrow_pkg
// Shared definitions for the arrow key decoder:
//   - arrow_t        : 3-bit arrow event codes delivered to the game processors
//   - KEY_* / PFX_*  : PS/2 set-2 scan codes the decoder reacts to
//   - parser_state_t : encoding of the make/break/extended parser states
//   - key_info_t     : result of a scan-code lookup (hit, player, arrow, slot)
//   - lookup_key()   : maps a scan byte onto its arrow, player and held slot
// -----------------------------------------------------------------------------
package arrow_pkg;

  typedef enum logic [2:0] {
    ARROW_NONE  = 3'd0,
    ARROW_UP    = 3'd1,
    ARROW_LEFT  = 3'd2,
    ARROW_DOWN  = 3'd3,
    ARROW_RIGHT = 3'd4
  } arrow_t;

  // Player 1 arrow keys (W/A/S/D-style cluster on the main block).
  localparam logic [7:0] KEY_P1_UP    = 8'h1D;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h23;

  // Player 2 arrow keys; arrive with or without the E0 prefix.
  localparam logic [7:0] KEY_P2_UP    = 8'h75;
  localparam logic [7:0] KEY_P2_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_P2_DOWN  = 8'h72;
  localparam logic [7:0] KEY_P2_RIGHT = 8'h74;

  localparam logic [7:0] KEY_RESET = 8'h2D;
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;

  // One held bit per mapped arrow key: slots 0-3 player 1, 4-7 player 2.
  localparam int NUM_KEYS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parser_state_t;

  typedef struct packed {
    logic       hit;     // byte is one of the eight arrow keys
    logic       player;  // 0 = player 1, 1 = player 2
    arrow_t     arrow;   // event code pushed on a make
    logic [2:0] idx;     // held-bitmap slot
  } key_info_t;

  function automatic key_info_t lookup_key(input logic [7:0] code);
    key_info_t info;
    info.hit    = 1'b1;
    info.player = 1'b0;
    info.arrow  = ARROW_NONE;
    info.idx    = 3'd0;
    case (code)
      KEY_P1_UP:    begin info.arrow = ARROW_UP;    info.idx = 3'd0; end
      KEY_P1_LEFT:  begin info.arrow = ARROW_LEFT;  info.idx = 3'd1; end
      KEY_P1_DOWN:  begin info.arrow = ARROW_DOWN;  info.idx = 3'd2; end
      KEY_P1_RIGHT: begin info.arrow = ARROW_RIGHT; info.idx = 3'd3; end
      KEY_P2_UP:    begin info.arrow = ARROW_UP;    info.idx = 3'd4; info.player = 1'b1; end
      KEY_P2_LEFT:  begin info.arrow = ARROW_LEFT;  info.idx = 3'd5; info.player = 1'b1; end
      KEY_P2_DOWN:  begin info.arrow = ARROW_DOWN;  info.idx = 3'd6; info.player = 1'b1; end
      KEY_P2_RIGHT: begin info.arrow = ARROW_RIGHT; info.idx = 3'd7; info.player = 1'b1; end
      default:      info.hit = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/arrow_key_decoder_if.sv
// -----------------------------------------------------------------------------
// arrow_key_decoder_if
// Bundles the scan-byte input, both player event ports and the status outputs.
//   scan_code/scan_valid : PS/2 byte and its one-cycle strobe
//   pN_arrow/pN_valid    : head of player N FIFO and its non-empty flag
//   pN_ready             : player N processor pops the head when valid
//   game_reset_req       : one-cycle pulse on a make of the reset key
//   overflow             : sticky drop flags, bit0 player 1, bit1 player 2
// Modports:
//   master : the surrounding system (PS/2 side and the two processors)
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface arrow_key_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [2:0] p1_arrow;
  logic       p1_valid;
  logic       p1_ready;
  logic [2:0] p2_arrow;
  logic       p2_valid;
  logic       p2_ready;
  logic       game_reset_req;
  logic [1:0] overflow;

  modport master (
    output scan_code, scan_valid, p1_ready, p2_ready,
    input  p1_arrow, p1_valid, p2_arrow, p2_valid, game_reset_req, overflow
  );

  modport slave (
    input  scan_code, scan_valid, p1_ready, p2_ready,
    output p1_arrow, p1_valid, p2_arrow, p2_valid, game_reset_req, overflow
  );
endinterface

// File: rtl/arrow_event_fifo.sv
// -----------------------------------------------------------------------------
// arrow_event_fifo
// Small synchronous FIFO of arrow events for one player.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i at the tail (accepted when not full, or when a
//                pop happens on the same edge)
//   data_i     : arrow code to write
//   pop_i      : remove the head; ignored while empty
//   flush_i    : empty the FIFO on this edge (wins over push/pop)
//   head_o     : combinational read of the head, ARROW_NONE when empty
//   full_o     : DEPTH entries held
//   empty_o    : no entries held (registered)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module arrow_event_fifo
  import arrow_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  arrow_t data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output arrow_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  arrow_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               pop_ok;
  logic               push_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = ~valid_q;
  assign pop_ok  = pop_i & valid_q;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push_i & (~full_o | pop_ok);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    valid_d = (count_d != '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was written, and head_o is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = valid_q ? mem_q[rd_ptr_q] : ARROW_NONE;

endmodule

// File: rtl/arrow_key_decoder.sv
// -----------------------------------------------------------------------------
// arrow_key_decoder
// Turns the raw PS/2 scan-byte stream into per-player arrow events.
//   clock, resetn : system clock, asynchronous active-low reset
//   bus (slave)   : scan_code/scan_valid in; pN_arrow/pN_valid/pN_ready per
//                   player; game_reset_req pulse; sticky overflow flags
// A parser FSM classifies each non-prefix byte as make or break. A held bitmap
// suppresses typematic repeats so a held key yields a single event. Events are
// buffered in one arrow_event_fifo per player. A make of the reset key pulses
// game_reset_req and returns the whole block to its idle condition.
// -----------------------------------------------------------------------------
module arrow_key_decoder
  import arrow_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic                clock,
  input logic                resetn,
  arrow_key_decoder_if.slave bus
);

  parser_state_t        state_q, state_d;
  logic [NUM_KEYS-1:0]  held_q, held_d;
  logic                 game_reset_q, game_reset_d;
  logic [1:0]           overflow_q, overflow_d;

  key_info_t            key;
  logic [1:0]           push;
  arrow_t               push_arrow;
  logic                 flush;
  logic [1:0]           fifo_full;
  logic [1:0]           fifo_empty;
  logic [1:0]           fifo_pop;
  arrow_t               head_p1, head_p2;

  assign key = lookup_key(bus.scan_code);

  // Parser, held bitmap and push decisions. Prefix bytes only move the FSM;
  // any other byte completes a sequence and returns the FSM to IDLE.
  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    game_reset_d = 1'b0;
    push         = '0;
    push_arrow   = key.arrow;
    flush        = 1'b0;

    if (bus.scan_valid) begin
      if (bus.scan_code == PFX_EXT) begin
        // E0 inside a break sequence or a repeated E0 leaves the state alone.
        if (state_q == ST_IDLE) state_d = ST_EXT;
      end else if (bus.scan_code == PFX_BRK) begin
        if (state_q == ST_IDLE)     state_d = ST_BRK;
        else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
      end else begin
        state_d = ST_IDLE;
        if (state_q == ST_IDLE || state_q == ST_EXT) begin
          if (bus.scan_code == KEY_RESET) begin
            game_reset_d = 1'b1;
            flush        = 1'b1;
            held_d       = '0;
          end else if (key.hit && !held_q[key.idx]) begin
            // The held bit is set even if the FIFO turns out to be full, so a
            // dropped key still needs a break before it can fire again.
            held_d[key.idx]   = 1'b1;
            push[key.player]  = 1'b1;
          end
        end else if (key.hit) begin
          held_d[key.idx] = 1'b0;
        end
      end
    end
  end

  // A push is dropped only when the FIFO is full and its head is not leaving
  // on the same edge; the reset key clears the flags.
  always_comb begin
    overflow_d = overflow_q | (push & fifo_full & ~fifo_pop);
    if (flush) overflow_d = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      held_q       <= '0;
      game_reset_q <= 1'b0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      game_reset_q <= game_reset_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fifo_pop[0] = ~fifo_empty[0] & bus.p1_ready;
  assign fifo_pop[1] = ~fifo_empty[1] & bus.p2_ready;

  arrow_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_p1 (
    .clk     (clock),
    .rst_n   (resetn),
    .push_i  (push[0]),
    .data_i  (push_arrow),
    .pop_i   (fifo_pop[0]),
    .flush_i (flush),
    .head_o  (head_p1),
    .full_o  (fifo_full[0]),
    .empty_o (fifo_empty[0])
  );

  arrow_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_p2 (
    .clk     (clock),
    .rst_n   (resetn),
    .push_i  (push[1]),
    .data_i  (push_arrow),
    .pop_i   (fifo_pop[1]),
    .flush_i (flush),
    .head_o  (head_p2),
    .full_o  (fifo_full[1]),
    .empty_o (fifo_empty[1])
  );

  assign bus.p1_arrow       = head_p1;
  assign bus.p1_valid       = ~fifo_empty[0];
  assign bus.p2_arrow       = head_p2;
  assign bus.p2_valid       = ~fifo_empty[1];
  assign bus.game_reset_req = game_reset_q;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_arrow_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_arrow_key_decoder
// Drives directed and random scan-byte streams into arrow_key_decoder. A
// behavioural model (prefix flags, held array, per-player expected queues)
// predicts each event; a negedge monitor compares the DUT outputs against the
// head of the expected queues and pops them as the processors accept events.
// -----------------------------------------------------------------------------
module tb_arrow_key_decoder;

  localparam int DEPTH = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #50 clock = ~clock;

  arrow_key_decoder_if bus_if ();

  arrow_key_decoder #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_if)
  );

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] key_tab [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
  bit   held [8];
  bit   ext_seen, brk_seen;
  int   exp_q1 [$];
  int   exp_q2 [$];
  bit [1:0] ovf_exp = 2'b00;
  bit   grr_exp = 1'b0;
  bit   r1 = 1'b1, r2 = 1'b1;

  task automatic clear_model();
    exp_q1.delete();
    exp_q2.delete();
    for (int i = 0; i < 8; i++) held[i] = 1'b0;
    ext_seen = 1'b0;
    brk_seen = 1'b0;
    ovf_exp  = 2'b00;
  endtask

  // Apply one cycle of stimulus (called just after a rising edge), predict
  // the outcome, then commit the prediction once the next edge has passed.
  task automatic step(input bit v, input logic [7:0] code, input bit rd1, input bit rd2);
    int push_p;
    int push_a;
    bit do_reset;
    bit pop1, pop2;
    bit [1:0] ovf_set;
    push_p   = -1;
    push_a   = 0;
    do_reset = 1'b0;
    ovf_set  = 2'b00;
    bus_if.scan_valid = v;
    bus_if.scan_code  = code;
    bus_if.p1_ready   = rd1;
    bus_if.p2_ready   = rd2;
    pop1 = rd1 && (exp_q1.size() > 0);
    pop2 = rd2 && (exp_q2.size() > 0);
    if (v) begin
      if (code == 8'hE0) begin
        if (!ext_seen && !brk_seen) ext_seen = 1'b1;
      end else if (code == 8'hF0) begin
        brk_seen = 1'b1;
      end else begin
        bit is_break;
        is_break = brk_seen;
        ext_seen = 1'b0;
        brk_seen = 1'b0;
        if (!is_break && code == 8'h2D) begin
          do_reset = 1'b1;
          for (int i = 0; i < 8; i++) held[i] = 1'b0;
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (key_tab[i] == code) begin
              if (is_break) held[i] = 1'b0;
              else if (!held[i]) begin
                int sz;
                bit pp;
                held[i] = 1'b1;
                sz = (i < 4) ? exp_q1.size() : exp_q2.size();
                pp = (i < 4) ? pop1 : pop2;
                if (sz == DEPTH && !pp) ovf_set[i/4] = 1'b1;
                else begin
                  push_p = i / 4;
                  push_a = (i % 4) + 1;
                end
              end
            end
          end
        end
      end
    end
    @(posedge clock);
    #1;
    grr_exp = do_reset;
    if (do_reset) begin
      exp_q1.delete();
      exp_q2.delete();
      ovf_exp = 2'b00;
    end else begin
      ovf_exp = ovf_exp | ovf_set;
      if (push_p == 0) exp_q1.push_back(push_a);
      else if (push_p == 1) exp_q2.push_back(push_a);
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, r1, r2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, r1, r2);
  endtask

  task automatic reset_pulse();
    resetn            = 1'b0;
    bus_if.scan_valid = 1'b0;
    clear_model();
    grr_exp = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!done) begin
      check("p1_valid", 32'(bus_if.p1_valid), 32'(exp_q1.size() != 0));
      if (exp_q1.size() != 0) begin
        check("p1_arrow", 32'(bus_if.p1_arrow), 32'(exp_q1[0]));
        if (bus_if.p1_ready) void'(exp_q1.pop_front());
      end else begin
        check("p1_arrow_empty", 32'(bus_if.p1_arrow), 32'd0);
      end
      check("p2_valid", 32'(bus_if.p2_valid), 32'(exp_q2.size() != 0));
      if (exp_q2.size() != 0) begin
        check("p2_arrow", 32'(bus_if.p2_arrow), 32'(exp_q2[0]));
        if (bus_if.p2_ready) void'(exp_q2.pop_front());
      end else begin
        check("p2_arrow_empty", 32'(bus_if.p2_arrow), 32'd0);
      end
      check("game_reset_req", 32'(bus_if.game_reset_req), 32'(grr_exp));
      check("overflow", 32'(bus_if.overflow), 32'(ovf_exp));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus_if.scan_valid = 1'b0;
    bus_if.scan_code  = 8'h00;
    bus_if.p1_ready   = 1'b1;
    bus_if.p2_ready   = 1'b1;
    clear_model();
    repeat (3) @(posedge clock);
    #1;
    check("reset_p1_valid", 32'(bus_if.p1_valid), 32'd0);
    check("reset_overflow", 32'(bus_if.overflow), 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Basic make / break / re-make for player 1.
    r1 = 1'b1; r2 = 1'b1;
    send(8'h1D); idle(2);
    send(8'hF0); send(8'h1D); idle(2);
    send(8'h1D); idle(2);
    send(8'hF0); send(8'h1D);

    // Typematic suppression on player 2 with the FIFO held.
    r2 = 1'b0;
    repeat (5) send(8'h74);
    idle(1);
    check("typematic_one_entry", 32'(bus_if.p2_valid), 32'd1);
    send(8'hF0); send(8'h74); send(8'h74);
    idle(1);
    r2 = 1'b1; idle(4);

    // Extended make / extended break / re-make.
    send(8'hE0); send(8'h6B); idle(1);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
    send(8'hE0); send(8'h6B); idle(2);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hF0); send(8'h74);

    // Overflow: six distinct-order makes into a stalled FIFO.
    r1 = 1'b0;
    send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h1B); send(8'hF0); send(8'h1B);
    send(8'h23); send(8'hF0); send(8'h23);
    send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'h1C); send(8'hF0); send(8'h1C);
    check("overflow_set", 32'(bus_if.overflow[0]), 32'd1);
    r1 = 1'b1; idle(6);
    check("overflow_sticky", 32'(bus_if.overflow[0]), 32'd1);

    // Reset key with both FIFOs holding entries.
    r1 = 1'b0; r2 = 1'b0;
    send(8'h1D); send(8'h75);
    send(8'h2D);
    check("grr_pulse", 32'(bus_if.game_reset_req), 32'd1);
    check("grr_overflow_clr", 32'(bus_if.overflow), 32'd0);
    idle(1);
    check("grr_one_cycle", 32'(bus_if.game_reset_req), 32'd0);
    send(8'hF0); send(8'h2D); idle(1);

    // Full FIFO with simultaneous push and pop.
    send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h1B); send(8'hF0); send(8'h1B);
    send(8'h23); send(8'hF0); send(8'h23);
    step(1'b1, 8'h1D, 1'b1, 1'b0);
    idle(1);
    check("full_pushpop_no_ovf", 32'(bus_if.overflow[0]), 32'd0);
    r1 = 1'b1; r2 = 1'b1; idle(6);
    send(8'hF0); send(8'h1D);

    // Reset pulse mid-sequence.
    send(8'hE0);
    reset_pulse();
    send(8'h75); idle(2);
    send(8'hE0); send(8'hF0);
    reset_pulse();
    send(8'h75); idle(2);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      int sel;
      logic [7:0] code;
      sel = int'($urandom_range(99));
      if (sel < 45)      code = key_tab[$urandom_range(7)];
      else if (sel < 60) code = 8'hE0;
      else if (sel < 80) code = 8'hF0;
      else if (sel < 82) code = 8'h2D;
      else               code = 8'($urandom);
      r1 = ($urandom_range(99) < 60);
      r2 = ($urandom_range(99) < 60);
      step(($urandom_range(99) < 70), code, r1, r2);
    end

    // Drain with a bounded cycle budget.
    r1 = 1'b1; r2 = 1'b1;
    for (int n = 0; n < 20 && (exp_q1.size() != 0 || exp_q2.size() != 0); n++) idle(1);
    idle(1);
    check("drain_p1_empty", 32'(exp_q1.size()), 32'd0);
    check("drain_p2_empty", 32'(exp_q2.size()), 32'd0);

    @(negedge clock);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
